// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage.
// Holds the fetch state encoding and the canonical NOP instruction word
// (addi x0, x0, 0) so every block in the fetch path agrees on them.
package fetch_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer for the fetch stage: a circular FIFO of DEPTH entries.
// Ports:
//   clk, rst  - rising-edge clock, asynchronous active-low reset
//   clear     - synchronous flush, wins over push/pop
//   push      - write wdata at the tail (caller guarantees space)
//   pop       - retire the head entry (caller guarantees non-empty)
//   wdata     - entry to write
//   rdata     - head entry
//   count     - number of valid entries, 0..DEPTH
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [WIDTH-1:0] mem [DEPTH];

    // DEPTH is a power of two, so the pointers wrap on their own.
    // Storage is zeroed on reset so the head reads as zero while held in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= wdata;
                tail      <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rdata = mem[head];

endmodule

// File: rtl/fetch_stage_buf.sv
// Instruction fetch stage with a prefetch buffer.
// Walks the PC through instruction memory while start is high, pushing
// {instr, pc, pc+4} into a small FIFO for decode; execute can redirect the
// PC, which flushes everything fetched down the wrong path.
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-low reset
//   start             - run enable; low returns to IDLE at RESET_PC
//   redirect_valid/pc - taken branch/jump target from execute
//   imem_addr         - current PC toward instruction memory
//   imem_rdata        - instruction word for imem_addr (combinational)
//   out_valid/ready   - decode handshake on the buffer head
//   out_instr/pc/pc_plus4 - head entry contents
module fetch_stage_buf
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 3 * XLEN;

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [CW-1:0]   count;
    logic [EW-1:0]   head_entry;
    logic            full;
    logic            pop;
    logic            push;
    logic            flush;

    assign pc_plus4  = pc + XLEN'(4);
    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    // Dropping start and redirecting both flush; dropping start wins because
    // it also forces the PC back to RESET_PC. A flush suppresses the push.
    assign flush = (state == FETCH) && (!start || redirect_valid);
    assign push  = (state == FETCH) && start && !redirect_valid && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    pc <= RESET_PC;
                    if (start) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (!start) begin
                        state <= IDLE;
                        pc    <= RESET_PC;
                    end else if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (push) begin
                        pc <= pc_plus4;
                    end
                end
                default: begin
                    state <= IDLE;
                    pc    <= RESET_PC;
                end
            endcase
        end
    end

    assign imem_addr = pc;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .pop   (pop && !flush),
        .wdata ({imem_rdata, pc, pc_plus4}),
        .rdata (head_entry),
        .count (count)
    );

    assign out_instr    = head_entry[3*XLEN-1:2*XLEN];
    assign out_pc       = head_entry[2*XLEN-1:XLEN];
    assign out_pc_plus4 = head_entry[XLEN-1:0];

endmodule

// File: tb/tb_fetch_stage_buf.sv
// Self-checking bench for fetch_stage_buf (XLEN=32, RESET_PC=0, DEPTH=4).
// A table of per-cycle vectors exercises the main flow, followed by
// hand-written sequences for stall, full pop+push, redirect, restart and
// asynchronous reset.
module tb_fetch_stage_buf;

    logic        clk;
    logic        rst;
    logic        start;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic        start;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[16];

    fetch_stage_buf #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4)
    );

    // Instruction memory: a distinct, non-zero word for every address.
    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        return {~addr[15:0], addr[15:0]} ^ 32'h0000_0013;
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive inputs just after an edge, then advance through the next edge.
    task automatic applyStimulus(input logic st, input logic rv,
                                 input logic [31:0] rpc, input logic rdy);
        start          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic exp_valid,
                               input logic [31:0] exp_pc, input logic [31:0] exp_addr);
        checkValue({name, ".valid"}, 32'(out_valid), 32'(exp_valid));
        checkValue({name, ".addr"}, imem_addr, exp_addr);
        if (exp_valid) begin
            checkValue({name, ".pc"}, out_pc, exp_pc);
            checkValue({name, ".pc4"}, out_pc_plus4, exp_pc + 32'd4);
            checkValue({name, ".instr"}, out_instr, imem_word(exp_pc));
        end
    endtask

    task automatic doReset();
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        rst            = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        //          start redir rpc           ready valid pc            addr
        vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h4};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'h8};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'hC};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h10};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h14};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h18};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h18};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        32'h1C};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       32'h20};
        vecs[10] = '{1'b1, 1'b1, 32'h100,      1'b1, 1'b0, 32'h0,        32'h100};
        vecs[11] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      32'h104};
        vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
        vecs[13] = '{1'b0, 1'b1, 32'h200,      1'b0, 1'b0, 32'h0,        32'h0};
        vecs[14] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
        vecs[15] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h4};

        // Reset values while rst is held low.
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        rst            = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkValue("rst.valid", 32'(out_valid), 32'h0);
        checkValue("rst.addr", imem_addr, 32'h0);
        checkValue("rst.instr", out_instr, 32'h0);
        checkValue("rst.pc", out_pc, 32'h0);
        checkValue("rst.pc4", out_pc_plus4, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].start, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                        vecs[i].exp_addr);
        end

        // Decode stalled for 10 cycles: buffer fills with 0..C, PC parks at 0x10.
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        end
        checkOutput("stall", 1'b1, 32'h0, 32'h10);
        checkValue("stall.count", 32'(dut.count), 32'd4);

        // Full buffer draining one per cycle while refilling: order kept, still full.
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
            checkOutput($sformatf("fullpp%0d", k), 1'b1, 32'(4 * k), 32'(32'h10 + 4 * k));
            checkValue($sformatf("fullpp%0d.count", k), 32'(dut.count), 32'd4);
        end

        // Drop start then raise it: restart from RESET_PC with an empty buffer.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("stop", 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("restart", 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        end
        checkOutput("three", 1'b1, 32'h0, 32'hC);
        checkValue("three.count", 32'(dut.count), 32'd3);

        // Redirect with three entries buffered and a head handshake in the same cycle.
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b1);
        checkOutput("redir", 1'b0, 32'h0, 32'h100);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("redir.next", 1'b1, 32'h100, 32'h104);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("redir.hold", 1'b1, 32'h100, 32'h108);

        // Asynchronous reset pulse mid-cycle while fetching.
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async", 1'b0, 32'h0, 32'h0);
        checkValue("async.pc", out_pc, 32'h0);
        checkValue("async.state", 32'(dut.state), 32'h0);
        start = 1'b0;
        #1;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("async.idle", 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("async.resume", 1'b1, 32'h0, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
